seq_detector_param: RTL and testbench

Parametrised serial sequence detector. The detector pattern, its don't-care mask and the overlap mode are set at run time. The block samples one serial bit `w` per qualified clock and compares the last `LEN` bits against the loaded pattern. On each hit it emits a registered one-cycle `match` pulse and keeps a saturating count of matches. It replaces the fixed hard-wired one-hot detectors in the lab designs and sits between switch/debounce logic and display or counter logic.

---
 rtl/seq_detect_pkg.sv | 24 ++
 rtl/seq_history.sv | 49 ++++
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_detect_pkg;

  // Legal pattern length range.
  localparam int LEN_MIN = 2;
  localparam int LEN_MAX = 16;

  // Defaults used when the detector is instantiated without overrides.
  localparam int                 DEF_LEN     = 4;
  localparam int                 DEF_CNT_W   = 8;
  localparam logic [LEN_MAX-1:0] DEF_PATTERN = 16'h000B;  // 4'b1011 in the low bits

  // Overlap mode as seen on the overlap input.
  typedef enum logic {
    MODE_DISJOINT = 1'b0,  // next match needs LEN fresh bits
    MODE_OVERLAP  = 1'b1   // next match may reuse bits of the previous one
  } overlap_mode_e;

  // True when a pattern length is inside the supported range.
  function automatic bit len_ok(input int len);
    return (len >= LEN_MIN) && (len <= LEN_MAX);
  endfunction

endpackage

// File: rtl/seq_history.sv
// Serial bit history for the sequence detector: LEN-bit shift register with
// newest bit at bit 0, plus a saturating count of how many bits are valid.
// The post-shift history and a "full after this shift" flag are exposed so the
// top level can decide a hit in the same cycle the completing bit arrives.
module seq_history
  import seq_detect_pkg::*;
#(
  parameter int LEN = DEF_LEN
) (
  input  logic           clk,
  input  logic           reset,     // synchronous, active-high
  input  logic           clear,     // drop history and fill (pattern load)
  input  logic           shift,     // accept w this cycle
  input  logic           restart,   // on a shift, restart fill from 0 (non-overlap hit)
  input  logic           w,
  output logic [LEN-1:0] h_next,    // history including w
  output logic           full_next  // fill would reach LEN with this shift
);

  localparam int             FW       = $clog2(LEN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(LEN);

  logic [LEN-1:0] hist;
  logic [FW-1:0]  fill;
  logic [FW-1:0]  f_next;

  // Candidate history and fill if the current bit is shifted in.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    h_next = {hist[LEN-2:0], w};
    f_next = (fill == FILL_MAX) ? FILL_MAX : fill + FW'(1);
  end

  assign full_next = (f_next == FILL_MAX);

  // History and fill registers; reset beats clear beats shift.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= h_next;
      fill <= restart ? '0 : f_next;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector. Compares the last LEN qualified bits
// against a run-time pattern with a per-bit don't-care mask, pulses match for
// one cycle per hit and keeps a saturating, sticky-flagged match count.
module seq_detector_param
  import seq_detect_pkg::*;
#(
  parameter int             LEN             = DEF_LEN,
  parameter int             CNT_W           = DEF_CNT_W,
  parameter logic [LEN-1:0] DEFAULT_PATTERN = LEN'(DEF_PATTERN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LEN-1:0]   pattern_in,
  input  logic [LEN-1:0]   mask_in,
  input  logic             overlap,
  input  logic             w_valid,
  input  logic             w,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  // Reject unsupported pattern lengths at elaboration.
  if (!len_ok(LEN)) begin : g_len_check
    $error("seq_detector_param: LEN must be within LEN_MIN..LEN_MAX");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LEN-1:0]   pat;
  logic [LEN-1:0]   msk;
  logic [LEN-1:0]   h_next;
  logic             full_next;
  logic             shift;
  logic             hit;
  logic             fill_restart;
  logic [CNT_W-1:0] cnt_next;

  // A bit arriving together with a load is discarded.
  assign shift = w_valid & ~load;

  seq_history #(
    .LEN (LEN)
  ) u_history (
    .clk       (clk),
    .reset     (reset),
    .clear     (load),
    .shift     (shift),
    .restart   (fill_restart),
    .w         (w),
    .h_next    (h_next),
    .full_next (full_next)
  );

  // Masked compare of the post-shift history, count increment and overlap handling.
  always_comb begin
    hit          = 1'b0;
    fill_restart = 1'b0;
    cnt_next     = match_count;
    if (shift && full_next) begin
      hit = &((h_next ~^ pat) | ~msk);
    end
    if (hit) begin
      fill_restart = (overlap_mode_e'(overlap) == MODE_DISJOINT);
      if (match_count != CNT_MAX) begin
        cnt_next = match_count + CNT_W'(1);
      end
    end
  end

  // Pattern/mask registers: default pattern with full compare after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat <= DEFAULT_PATTERN;
      msk <= '1;
    end else if (load) begin
      pat <= pattern_in;
      msk <= mask_in;
    end
  end

  // Registered outputs: one-cycle match pulse, saturating count, sticky flag.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match <= hit;
      if (hit) begin
        match_count <= cnt_next;
        count_sat   <= count_sat | (cnt_next == CNT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (LEN=4). A second
// instance with a 2-bit counter shares the stimulus for the saturation case.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] pattern_in;
  logic [3:0] mask_in;
  logic       overlap;
  logic       w_valid;
  logic       w;

  logic       match_a, sat_a;
  logic [7:0] count_a;
  logic       match_b, sat_b;
  logic [1:0] count_b;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(.LEN(4), .CNT_W(8), .DEFAULT_PATTERN(4'b1011)) dut_a (
    .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in), .mask_in(mask_in),
    .overlap(overlap), .w_valid(w_valid), .w(w),
    .match(match_a), .match_count(count_a), .count_sat(sat_a)
  );

  seq_detector_param #(.LEN(4), .CNT_W(2), .DEFAULT_PATTERN(4'b1011)) dut_b (
    .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in), .mask_in(mask_in),
    .overlap(overlap), .w_valid(w_valid), .w(w),
    .match(match_b), .match_count(count_b), .count_sat(sat_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all three outputs of the 8-bit-counter instance.
  task automatic check_a(input string tag, input int m, input int c, input int s);
    check({tag, ".match"}, {31'b0, match_a}, m);
    check({tag, ".count"}, {24'b0, count_a}, c);
    check({tag, ".sat"},   {31'b0, sat_a},   s);
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    w_valid = 1'b1;
    w       = b;
    cyc();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    w_valid = 1'b0;
    cyc();
    reset   = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] p, input logic [3:0] m);
    load       = 1'b1;
    pattern_in = p;
    mask_in    = m;
    w_valid    = 1'b0;
    cyc();
    load       = 1'b0;
  endtask

  logic [6:0] stream;
  int ovl_m[7]   = '{0, 0, 0, 1, 0, 0, 1};
  int ovl_c[7]   = '{0, 0, 0, 1, 1, 1, 2};
  int dis_m[7]   = '{0, 0, 0, 1, 0, 0, 0};
  int sat_m[7]   = '{0, 0, 0, 1, 1, 1, 1};
  int sat_ca[7]  = '{0, 0, 0, 1, 2, 3, 4};
  int sat_cb[7]  = '{0, 0, 0, 1, 2, 3, 3};
  int sat_sb[7]  = '{0, 0, 0, 0, 0, 1, 1};

  initial begin
    reset = 1'b1; load = 1'b0; pattern_in = '0; mask_in = '0;
    overlap = 1'b1; w_valid = 1'b0; w = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state
    check_a("reset", 0, 0, 0);
    check("reset.count_b", {30'b0, count_b}, 0);
    check("reset.sat_b", {31'b0, sat_b}, 0);

    // Overlap mode with default pattern 1011 on 1,0,1,1,0,1,1
    stream = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      bit_in(stream[6-i]);
      check($sformatf("ovl.bit%0d.match", i + 1), {31'b0, match_a}, ovl_m[i]);
      check($sformatf("ovl.bit%0d.count", i + 1), {24'b0, count_a}, ovl_c[i]);
    end

    // Load colliding with a valid bit: bit dropped, count cleared from 2
    load = 1'b1; pattern_in = 4'b1011; mask_in = 4'hF; w_valid = 1'b1; w = 1'b1;
    cyc();
    load = 1'b0;
    check_a("collide", 0, 0, 0);
    bit_in(1'b0);
    bit_in(1'b1);
    bit_in(1'b1);
    check("collide.discarded", {31'b0, match_a}, 0);

    // Non-overlap mode on the same stream
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_in(stream[6-i]);
      check($sformatf("disj.bit%0d.match", i + 1), {31'b0, match_a}, dis_m[i]);
    end
    check("disj.count", {24'b0, count_a}, 1);

    // Masked compare: pattern 1001, mask 1001
    overlap = 1'b1;
    do_load(4'b1001, 4'b1001);
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b1);
    check("mask.bit3.match", {31'b0, match_a}, 0);
    bit_in(1'b1);
    check_a("mask.bit4", 1, 1, 0);
    bit_in(1'b0);
    check_a("mask.bit5", 0, 1, 0);
    w_valid = 1'b0;
    cyc();
    check_a("mask.idle", 0, 1, 0);
    bit_in(1'b1);
    check_a("mask.bit6", 1, 2, 0);

    // All-zero mask: every bit matches once fill reaches LEN
    do_load(4'b0000, 4'b0000);
    bit_in(1'b0);
    bit_in(1'b1);
    bit_in(1'b0);
    check_a("nomask.bit3", 0, 0, 0);
    bit_in(1'b1);
    check_a("nomask.bit4", 1, 1, 0);
    bit_in(1'b0);
    check_a("nomask.bit5", 1, 2, 0);

    // Reset mid-stream restores default pattern and discards history
    do_load(4'b0000, 4'hF);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    reset = 1'b1; w_valid = 1'b1; w = 1'b1;
    cyc();
    reset = 1'b0;
    check_a("midrst", 0, 0, 0);
    bit_in(1'b1);
    check("midrst.bit1.match", {31'b0, match_a}, 0);
    bit_in(1'b0);
    bit_in(1'b1);
    check("midrst.bit3.match", {31'b0, match_a}, 0);
    bit_in(1'b1);
    check_a("midrst.default_pat", 1, 1, 0);

    // Saturation: pattern 1111, seven ones, back-to-back overlapping hits
    overlap = 1'b1;
    do_load(4'b1111, 4'hF);
    for (int i = 0; i < 7; i++) begin
      bit_in(1'b1);
      check($sformatf("sat.bit%0d.match_a", i + 1), {31'b0, match_a}, sat_m[i]);
      check($sformatf("sat.bit%0d.count_a", i + 1), {24'b0, count_a}, sat_ca[i]);
      check($sformatf("sat.bit%0d.match_b", i + 1), {31'b0, match_b}, sat_m[i]);
      check($sformatf("sat.bit%0d.count_b", i + 1), {30'b0, count_b}, sat_cb[i]);
      check($sformatf("sat.bit%0d.sat_b", i + 1),   {31'b0, sat_b},   sat_sb[i]);
    end
    check("sat.sat_a", {31'b0, sat_a}, 0);
    do_load(4'b1111, 4'hF);
    check("sat.cleared_by_load", {31'b0, sat_b}, 0);
    check("sat.count_cleared", {30'b0, count_b}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
